// File: rtl/sodor_isa_pkg.sv
// Shared RV32I encoding constants, LFSR taps and enums for the stimulus generator.
package sodor_isa_pkg;

  localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    CLS_OPIMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_OP
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_WARMUP,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } gen_state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

endpackage

// File: rtl/lfsr64.sv
// 64-bit Galois LFSR with synchronous reload and an advance strobe.
module lfsr64
  import sodor_isa_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  output logic [63:0] state
);

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  localparam logic [63:0] SEED_NZ = (SEED == 64'h0) ? 64'h1 : SEED;

  // Hold, reload or step the LFSR state.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state <= SEED_NZ;
    end else if (load) begin
      state <= SEED_NZ;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/instr_stim_gen.sv
// Seeded random RV32I instruction source (OP-IMM/LOAD/STORE/OP) with valid/ready output,
// warm-up NOP preamble, optional read-after-write hazard forcing and an instruction budget.
module instr_stim_gen
  import sodor_isa_pkg::*;
#(
  parameter logic [63:0] SEED         = 64'h1,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned W_ALU        = 8,
  parameter int unsigned W_LOAD       = 8,
  parameter int unsigned W_STORE      = 0,
  parameter logic [2:0]  LOAD_F3_MASK = 3'b100,
  parameter logic [11:0] IMM_L_MASK   = 12'hFFF,
  parameter int unsigned WARMUP_NOPS  = 2,
  parameter logic [31:0] NUM_INSTRS   = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        hazard_en,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] count,
  output logic        done
);

  localparam logic [4:0] TH_ALU   = 5'(W_ALU);
  localparam logic [4:0] TH_LOAD  = 5'(W_ALU + W_LOAD);
  localparam logic [4:0] TH_STORE = 5'(W_ALU + W_LOAD + W_STORE);
  localparam logic [4:0] REG_MASK = 5'(NUM_REGS - 1);
  localparam gen_state_e INIT_STATE = (WARMUP_NOPS == 0) ? ST_RUN : ST_WARMUP;

  gen_state_e   state;
  logic [31:0]  nops_left;
  logic [63:0]  lfsr_q;
  logic [63:0]  lfsr_d;
  logic         accept;
  logic         cur_writes_rd;
  logic [4:0]   last_rd_q, last_rd_d;
  logic         last_rd_vld_q, last_rd_vld_d;

  logic [31:0]  cand_word;
  logic         cand_writes_rd;
  instr_class_e cls;
  logic [4:0]   cls_bits;
  logic [11:0]  imm, imm_i, imm_l;
  logic [4:0]   rs1, rs2, rd;
  logic [2:0]   f3;
  logic [1:0]   f3s;
  logic [6:0]   funct7;
  logic [28:0]  lfsr_unused;

  assign accept = instr_valid & instr_ready;

  lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (1'b0),
    .advance (accept),
    .state   (lfsr_q)
  );

  // The word loaded at an accept is drawn from the post-advance state, so the
  // presented word always corresponds to the LFSR state currently held.
  assign lfsr_d      = accept ? lfsr_step(lfsr_q) : lfsr_q;
  assign lfsr_unused = lfsr_d[63:35];

  // Track the most recent nonzero destination register, including the one being accepted now.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    last_rd_d     = last_rd_q;
    last_rd_vld_d = last_rd_vld_q;
    if (accept && cur_writes_rd && instr[11:7] != 5'd0) begin
      last_rd_d     = instr[11:7];
      last_rd_vld_d = 1'b1;
    end
  end

  // Decode LFSR fields into the next candidate instruction.
  always_comb begin
    imm      = lfsr_d[11:0];
    rs1      = lfsr_d[16:12] & REG_MASK;
    rs2      = lfsr_d[21:17] & REG_MASK;
    rd       = lfsr_d[26:22] & REG_MASK;
    f3       = lfsr_d[29:27];
    cls_bits = {1'b0, lfsr_d[34:31]};
    if (hazard_en && last_rd_vld_d) begin
      rs1 = last_rd_d;
    end

    if (cls_bits < TH_ALU)        cls = CLS_OPIMM;
    else if (cls_bits < TH_LOAD)  cls = CLS_LOAD;
    else if (cls_bits < TH_STORE) cls = CLS_STORE;
    else                          cls = CLS_OP;

    // Shift-immediate forms only keep shamt (and the SRAI bit for f3==5).
    imm_i = imm;
    if (f3 == 3'd1)      imm_i = imm & 12'h01F;
    else if (f3 == 3'd5) imm_i = imm & 12'h41F;

    imm_l  = imm & IMM_L_MASK;
    f3s    = (lfsr_d[28:27] == 2'd3) ? 2'd2 : lfsr_d[28:27];
    funct7 = {1'b0, lfsr_d[30] & (f3 == 3'd0 || f3 == 3'd5), 5'b0};

    cand_writes_rd = 1'b1;
    cand_word      = NOP_WORD;
    unique case (cls)
      CLS_OPIMM: cand_word = {imm_i, rs1, f3, rd, OPC_OPIMM};
      CLS_LOAD:  cand_word = {imm_l, rs1, f3 & LOAD_F3_MASK, rd, OPC_LOAD};
      CLS_STORE: begin
        cand_word      = {imm_l[11:5], rs2, rs1, 1'b0, f3s, imm_l[4:0], OPC_STORE};
        cand_writes_rd = 1'b0;
      end
      CLS_OP:    cand_word = {funct7, rs2, rs1, f3, rd, OPC_OP};
      default:   cand_word = NOP_WORD;
    endcase
  end

  // Control FSM with registered instruction, valid, count and done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= INIT_STATE;
      nops_left     <= 32'(WARMUP_NOPS);
      instr         <= NOP_WORD;
      instr_valid   <= 1'b0;
      cur_writes_rd <= 1'b0;
      count         <= '0;
      done          <= 1'b0;
      last_rd_q     <= '0;
      last_rd_vld_q <= 1'b0;
    end else begin
      last_rd_q     <= last_rd_d;
      last_rd_vld_q <= last_rd_vld_d;
      unique case (state)
        ST_WARMUP: begin
          instr_valid <= 1'b1;
          if (accept) begin
            nops_left <= nops_left - 32'd1;
            if (nops_left == 32'd1) begin
              state         <= ST_RUN;
              instr         <= cand_word;
              cur_writes_rd <= cand_writes_rd;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            count <= (count == '1) ? count : count + 32'd1;
            if (NUM_INSTRS != 32'd0 && count + 32'd1 == NUM_INSTRS) begin
              state       <= ST_DONE;
              instr_valid <= 1'b0;
              done        <= 1'b1;
            end else begin
              instr         <= cand_word;
              cur_writes_rd <= cand_writes_rd;
              instr_valid   <= en;
              if (!en) state <= ST_PAUSE;
            end
          end else if (!instr_valid) begin
            instr         <= cand_word;
            cur_writes_rd <= cand_writes_rd;
            instr_valid   <= en;
            if (!en) state <= ST_PAUSE;
          end
          // valid & !ready: hold the word even if en has dropped.
        end
        ST_PAUSE: begin
          instr         <= cand_word;
          cur_writes_rd <= cand_writes_rd;
          if (en) begin
            state       <= ST_RUN;
            instr_valid <= 1'b1;
          end
        end
        ST_DONE: instr_valid <= 1'b0;
        default: state <= ST_WARMUP;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stim_gen.sv
// Scoreboard bench for instr_stim_gen: an independent LFSR/encoder model predicts every word.
module tb_instr_stim_gen;

  localparam logic [63:0] P_SEED    = 64'h0123_4567_89AB_CDEF;
  localparam int          P_REGS    = 8;
  localparam int          P_ALU     = 6;
  localparam int          P_LOAD    = 4;
  localparam int          P_STORE   = 3;
  localparam logic [2:0]  P_LF3     = 3'b100;
  localparam logic [11:0] P_IMASK   = 12'h7FF;
  localparam int          P_NOPS    = 2;
  localparam logic [31:0] P_INSTRS  = 32'd40;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, en, hazard_en, instr_ready;
  logic [31:0] instr, count;
  logic        instr_valid, done;

  always #5 clk = ~clk;

  instr_stim_gen #(
    .SEED(P_SEED), .NUM_REGS(P_REGS), .W_ALU(P_ALU), .W_LOAD(P_LOAD), .W_STORE(P_STORE),
    .LOAD_F3_MASK(P_LF3), .IMM_L_MASK(P_IMASK), .WARMUP_NOPS(P_NOPS), .NUM_INSTRS(P_INSTRS)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .hazard_en(hazard_en), .instr_ready(instr_ready),
    .instr(instr), .instr_valid(instr_valid), .count(count), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  typedef struct packed {
    logic        writes_rd;
    logic        is_rand;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_s;
  int          m_nops;
  logic [4:0]  m_lrd;
  logic        m_lrd_v, m_done, m_paused, m_hz;
  logic [31:0] m_count;

  logic [31:0] rec[16];
  int          rec_n = 0, rep_n = 0;
  logic        rec_on = 1'b0, rep_on = 1'b0;

  function automatic logic [63:0] m_step(input logic [63:0] s);
    logic [63:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 64'hD800_0000_0000_0000;
    return n;
  endfunction

  // Reference encoder written directly from the field layout of each format.
  function automatic exp_t m_word(input logic [63:0] s, input logic hz,
                                  input logic [4:0] lrd, input logic lrd_v);
    exp_t        e;
    logic [11:0] imm;
    logic [4:0]  r1, r2, rdd;
    logic [2:0]  f3;
    logic [1:0]  sf;
    int          c;
    imm = s[11:0];
    r1  = s[16:12] & 5'(P_REGS - 1);
    r2  = s[21:17] & 5'(P_REGS - 1);
    rdd = s[26:22] & 5'(P_REGS - 1);
    f3  = s[29:27];
    c   = int'(s[34:31]);
    if (hz && lrd_v) r1 = lrd;
    e.is_rand   = 1'b1;
    e.writes_rd = 1'b1;
    if (c < P_ALU) begin
      if (f3 == 3'd1) imm = imm & 12'h01F;
      if (f3 == 3'd5) imm = imm & 12'h41F;
      e.word = {imm, r1, f3, rdd, 7'b0010011};
    end else if (c < P_ALU + P_LOAD) begin
      e.word = {imm & P_IMASK, r1, f3 & P_LF3, rdd, 7'b0000011};
    end else if (c < P_ALU + P_LOAD + P_STORE) begin
      imm = imm & P_IMASK;
      sf  = (s[28:27] == 2'b11) ? 2'b10 : s[28:27];
      e.word      = {imm[11:5], r2, r1, 1'b0, sf, imm[4:0], 7'b0100011};
      e.writes_rd = 1'b0;
    end else begin
      e.word = {1'b0, s[30] & (f3 == 3'd0 || f3 == 3'd5), 5'b0, r2, r1, f3, rdd, 7'b0110011};
    end
    return e;
  endfunction

  task automatic model_reset(input logic hz);
    exp_q.delete();
    m_s = P_SEED; m_nops = P_NOPS; m_lrd = '0; m_lrd_v = 1'b0;
    m_count = '0; m_done = 1'b0; m_paused = 1'b0; m_hz = hz;
    for (int i = 0; i < P_NOPS; i++) exp_q.push_back('{writes_rd: 1'b0, is_rand: 1'b0, word: NOP});
  endtask

  // Compare DUT outputs against the model, then retire the word if it is being accepted.
  task automatic observe();
    exp_t e;
    check("valid", 64'(instr_valid), 64'(!m_done && !m_paused));
    check("done", 64'(done), 64'(m_done));
    check("count", 64'(count), 64'(m_count));
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'(instr), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("word", 64'(instr), 64'(e.word));
        if (rec_on && rec_n < 16) begin rec[rec_n] = instr; rec_n++; end
        if (rep_on && rep_n < 16) begin check("replay", 64'(instr), 64'(rec[rep_n])); rep_n++; end
        if (e.is_rand) begin
          check("rs1_range", 64'(instr[19:18]), 64'd0);
          if (m_hz && m_lrd_v) check("haz_rs1", 64'(instr[19:15]), 64'(m_lrd));
        end
        m_s = m_step(m_s);
        if (e.writes_rd && e.word[11:7] != 5'd0) begin m_lrd = e.word[11:7]; m_lrd_v = 1'b1; end
        if (e.is_rand) begin
          m_count++;
          if (m_count == P_INSTRS) m_done = 1'b1;
          else if (!en) m_paused = 1'b1;
        end else begin
          m_nops--;
        end
        if (!m_done && m_nops == 0) exp_q.push_back(m_word(m_s, m_hz, m_lrd, m_lrd_v));
      end
    end
  endtask

  task automatic tick(input logic rdy, input logic en_v);
    @(negedge clk);
    instr_ready = rdy;
    en          = en_v;
    observe();
    if (en_v) m_paused = 1'b0;
  endtask

  // Assert reset between clock edges and check the asynchronous clear before any edge.
  task automatic async_reset(input logic hz);
    @(negedge clk);
    #2;
    reset     = 1'b1;
    hazard_en = hz;
    #1;
    check("rst_instr", 64'(instr), 64'(NOP));
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset(hz);
  endtask

  task automatic run_to_done(input int max_cycles);
    for (int i = 0; i < max_cycles && !m_done; i++) tick($urandom_range(0, 3) != 0, 1'b1);
    if (!m_done) check("done_timeout", 64'd0, 64'd1);
    repeat (3) tick(1'b1, 1'b1);
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; hazard_en = 1'b0; instr_ready = 1'b0;

    // Warm-up NOPs, then a free-running stream.
    async_reset(1'b0);
    rec_on = 1'b1;
    repeat (12) tick(1'b1, 1'b1);

    // Backpressure: word must hold while stalled.
    repeat (5) begin
      tick(1'b0, 1'b1);
      if (exp_q.size() > 0) check("stall_hold", 64'(instr), 64'(exp_q[0].word));
    end

    // en drops mid-handshake: valid stays until accepted, then pauses.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    repeat (4) tick(1'b1, 1'b1);
    run_to_done(400);
    rec_on = 1'b0;

    // Mid-stream reset restarts the identical stream.
    async_reset(1'b0);
    repeat (10) tick(1'b1, 1'b1);
    async_reset(1'b0);
    rep_on = 1'b1;
    run_to_done(400);
    rep_on = 1'b0;
    check("replay_len", 64'(rep_n), 64'd16);

    // Hazard mode.
    async_reset(1'b1);
    run_to_done(400);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
